match_controller: RTL and testbench

MATCH_CONTROLLER -- requirements
Module: match_controller

---
 rtl/game_pkg.sv | 33 +++
 rtl/blast_zone_check.sv | 23 ++
 rtl/match_controller.sv | 139 +++++++++++++
 tb/tb_match_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the match controller: FSM states, winner codes and the
// bit layout of a packed player position word.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_RESPAWN   = 3'd3,
        ST_OVER      = 3'd4
    } match_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    localparam int POS_X_HI = 31;
    localparam int POS_X_LO = 16;
    localparam int POS_Y_HI = 15;
    localparam int POS_Y_LO = 0;

    // Stock never goes below zero, even if a KO lands on an empty counter.
    function automatic logic [15:0] sat_dec(input logic [15:0] value, input logic hit);
        if (hit && value != 16'd0) begin
            return value - 16'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/blast_zone_check.sv
// Flags a player as knocked out once its position leaves the arena; positions
// are unsigned, so a player flung past zero wraps large and is caught too.
module blast_zone_check
    import game_pkg::*;
#(
    parameter int unsigned X_MAX = 640,
    parameter int unsigned Y_MAX = 480
) (
    input  logic [31:0] pos,
    output logic        ko
);

    localparam logic [31:0] X_LIMIT = 32'(X_MAX);
    localparam logic [31:0] Y_LIMIT = 32'(Y_MAX);

    logic [31:0] x_ext;
    logic [31:0] y_ext;

    assign x_ext = {16'd0, pos[POS_X_HI:POS_X_LO]};
    assign y_ext = {16'd0, pos[POS_Y_HI:POS_Y_LO]};
    assign ko    = (x_ext >= X_LIMIT) || (y_ext >= Y_LIMIT);

endmodule

// File: rtl/match_controller.sv
// Two-player match sequencer: countdown, play with blast-zone KO detection,
// respawn freeze and game-over, with all outputs registered.
module match_controller
    import game_pkg::*;
#(
    parameter int unsigned X_MAX          = 640,
    parameter int unsigned Y_MAX          = 480,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned CD_CYCLES      = 50000000,
    parameter int unsigned RESPAWN_CYCLES = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pos1,
    input  logic [31:0] pos2,
    output logic [2:0]  state,
    output logic        freeze,
    output logic [1:0]  respawn,
    output logic [15:0] lives1,
    output logic [15:0] lives2,
    output logic [1:0]  winner
);

    localparam logic [31:0] CD_LOAD      = 32'(CD_CYCLES - 1);
    localparam logic [31:0] RESPAWN_LOAD = 32'(RESPAWN_CYCLES - 1);
    localparam logic [15:0] LIVES_INIT   = 16'(LIVES);

    match_state_t state_r;
    logic [31:0]  timer;
    logic         start_q;
    logic         start_edge;
    logic         ko1;
    logic         ko2;
    logic [15:0]  lives1_next;
    logic [15:0]  lives2_next;
    logic         out1;
    logic         out2;

    blast_zone_check #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_zone1 (
        .pos (pos1),
        .ko  (ko1)
    );

    blast_zone_check #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_zone2 (
        .pos (pos2),
        .ko  (ko2)
    );

    assign start_edge  = start && !start_q;
    assign lives1_next = sat_dec(lives1, ko1);
    assign lives2_next = sat_dec(lives2, ko2);
    assign out1        = (lives1_next == 16'd0);
    assign out2        = (lives2_next == 16'd0);
    assign state       = state_r;

    // start_q resets high so a button held through reset cannot fake an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            freeze  <= 1'b1;
            respawn <= 2'b00;
            winner  <= WIN_NONE;
            lives1  <= LIVES_INIT;
            lives2  <= LIVES_INIT;
            timer   <= 32'd0;
            start_q <= 1'b1;
        end else begin
            start_q <= start;
            respawn <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    freeze <= 1'b1;
                    winner <= WIN_NONE;
                    if (start_edge) begin
                        state_r <= ST_COUNTDOWN;
                        timer   <= CD_LOAD;
                        lives1  <= LIVES_INIT;
                        lives2  <= LIVES_INIT;
                    end
                end
                ST_COUNTDOWN: begin
                    if (timer == 32'd0) begin
                        state_r <= ST_PLAY;
                        freeze  <= 1'b0;
                    end else begin
                        freeze <= 1'b1;
                        timer  <= timer - 32'd1;
                    end
                end
                ST_PLAY: begin
                    freeze <= 1'b0;
                    if (ko1 || ko2) begin
                        lives1  <= lives1_next;
                        lives2  <= lives2_next;
                        respawn <= {ko2, ko1};
                        freeze  <= 1'b1;
                        if (out1 || out2) begin
                            state_r <= ST_OVER;
                            if (out1 && out2) begin
                                winner <= WIN_DRAW;
                            end else if (out1) begin
                                winner <= WIN_P2;
                            end else begin
                                winner <= WIN_P1;
                            end
                        end else begin
                            state_r <= ST_RESPAWN;
                            timer   <= RESPAWN_LOAD;
                        end
                    end
                end
                ST_RESPAWN: begin
                    if (timer == 32'd0) begin
                        state_r <= ST_PLAY;
                        freeze  <= 1'b0;
                    end else begin
                        freeze <= 1'b1;
                        timer  <= timer - 32'd1;
                    end
                end
                ST_OVER: begin
                    freeze <= 1'b1;
                    if (start_edge) begin
                        state_r <= ST_IDLE;
                        winner  <= WIN_NONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    freeze  <= 1'b1;
                    winner  <= WIN_NONE;
                    timer   <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match scenarios with literal checks,
// then random play, all compared every cycle against a behavioural model.
module tb_match_controller;

    localparam int CD = 4;
    localparam int RC = 3;
    localparam int LV = 2;
    localparam int XM = 640;
    localparam int YM = 480;

    localparam logic [31:0] IN_ZONE  = 32'h0064_0064;
    localparam logic [31:0] X_EDGE   = 32'h0280_0064;
    localparam logic [31:0] Y_WRAP   = 32'h0100_FFF0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b1;
    logic [31:0] pos1  = IN_ZONE;
    logic [31:0] pos2  = IN_ZONE;
    logic [2:0]  state;
    logic        freeze;
    logic [1:0]  respawn;
    logic [15:0] lives1;
    logic [15:0] lives2;
    logic [1:0]  winner;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    match_controller #(
        .X_MAX(XM), .Y_MAX(YM), .LIVES(LV), .CD_CYCLES(CD), .RESPAWN_CYCLES(RC)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .pos1    (pos1),
        .pos2    (pos2),
        .state   (state),
        .freeze  (freeze),
        .respawn (respawn),
        .lives1  (lives1),
        .lives2  (lives2),
        .winner  (winner)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit off_stage(input logic [31:0] p);
        int x;
        int y;
        x = int'(p[31:16]);
        y = int'(p[15:0]);
        return (x >= XM) || (y >= YM);
    endfunction

    // Model phases use the numbering of the state output; m_left counts the
    // clocks still to be spent in a timed phase.
    int m_phase;
    int m_left;
    int m_l1;
    int m_l2;
    int m_win;
    int m_resp;
    bit m_sq;
    bit m_valid = 1'b0;
    bit m_edge;
    bit m_k1;
    bit m_k2;

    always @(posedge clock) begin
        m_edge = start && !m_sq;
        if (reset) begin
            m_phase = 0;
            m_left  = 0;
            m_l1    = LV;
            m_l2    = LV;
            m_win   = 0;
            m_resp  = 0;
            m_sq    = 1'b1;
            m_valid = 1'b1;
        end else begin
            m_sq   = start;
            m_resp = 0;
            case (m_phase)
                0: begin
                    m_win = 0;
                    if (m_edge) begin
                        m_phase = 1;
                        m_left  = CD;
                        m_l1    = LV;
                        m_l2    = LV;
                    end
                end
                1, 3: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                2: begin
                    m_k1 = off_stage(pos1);
                    m_k2 = off_stage(pos2);
                    if (m_k1 || m_k2) begin
                        if (m_k1 && m_l1 > 0) m_l1 = m_l1 - 1;
                        if (m_k2 && m_l2 > 0) m_l2 = m_l2 - 1;
                        m_resp = (m_k1 ? 1 : 0) + (m_k2 ? 2 : 0);
                        if (m_l1 == 0 || m_l2 == 0) begin
                            m_phase = 4;
                            if (m_l1 == 0 && m_l2 == 0) m_win = 3;
                            else if (m_l1 == 0)         m_win = 2;
                            else                        m_win = 1;
                        end else begin
                            m_phase = 3;
                            m_left  = RC;
                        end
                    end
                end
                default: begin
                    if (m_edge) begin
                        m_phase = 0;
                        m_win   = 0;
                    end
                end
            endcase
        end
        #1;
        if (m_valid) begin
            checkOutput("model_state",   int'(state),   m_phase);
            checkOutput("model_freeze",  int'(freeze),  (m_phase == 2) ? 0 : 1);
            checkOutput("model_respawn", int'(respawn), m_resp);
            checkOutput("model_lives1",  int'(lives1),  m_l1);
            checkOutput("model_lives2",  int'(lives2),  m_l2);
            checkOutput("model_winner",  int'(winner),  m_win);
        end
    end

    // Drive one clock's worth of inputs, then return just after the edge.
    task automatic applyStimulus(input bit rst, input bit st,
                                 input logic [31:0] p1, input logic [31:0] p2);
        @(negedge clock);
        reset = rst;
        start = st;
        pos1  = p1;
        pos2  = p2;
        @(posedge clock);
        #2;
    endtask

    task automatic wait_state(input int target, input int budget);
        int n;
        n = 0;
        while (int'(state) != target && n < budget) begin
            applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
            n++;
        end
        checkOutput("wait_state", int'(state), target);
    endtask

    function automatic logic [31:0] rand_pos();
        logic [15:0] x;
        logic [15:0] y;
        x = 16'($urandom_range(0, XM - 1));
        y = 16'($urandom_range(0, YM - 1));
        case ($urandom_range(0, 59))
            0: x = 16'($urandom_range(XM, XM + 60));
            1: y = 16'($urandom_range(YM, YM + 40));
            2: y = 16'($urandom_range(16'hFF00, 16'hFFFF));
            default: ;
        endcase
        return {x, y};
    endfunction

    initial begin
        int cnt;
        bit rst;
        bit st;

        // Button held through reset must not start a match.
        repeat (3) applyStimulus(1'b1, 1'b1, IN_ZONE, IN_ZONE);
        checkOutput("reset_state",   int'(state),   0);
        checkOutput("reset_freeze",  int'(freeze),  1);
        checkOutput("reset_lives1",  int'(lives1),  2);
        checkOutput("reset_respawn", int'(respawn), 0);
        applyStimulus(1'b0, 1'b1, IN_ZONE, IN_ZONE);
        checkOutput("held_start_ignored", int'(state), 0);
        applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
        applyStimulus(1'b0, 1'b1, IN_ZONE, IN_ZONE);
        checkOutput("countdown_entry", int'(state), 1);

        cnt = 1;
        while (int'(state) == 1 && cnt < 20) begin
            applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
            if (int'(state) == 1) cnt++;
        end
        checkOutput("countdown_len", cnt, 4);
        checkOutput("play_entry",    int'(state),  2);
        checkOutput("play_freeze",   int'(freeze), 0);

        // x exactly at the bound is a KO; the pos1 stays out during respawn.
        applyStimulus(1'b0, 1'b0, X_EDGE, IN_ZONE);
        checkOutput("ko1_lives1",  int'(lives1),  1);
        checkOutput("ko1_respawn", int'(respawn), 1);
        checkOutput("ko1_state",   int'(state),   3);
        cnt = 1;
        while (int'(state) == 3 && cnt < 20) begin
            applyStimulus(1'b0, 1'b0, X_EDGE, IN_ZONE);
            if (int'(state) == 3) cnt++;
        end
        checkOutput("respawn_len",      cnt,          3);
        checkOutput("respawn_no_ko",    int'(lives1), 1);
        checkOutput("respawn_to_play",  int'(state),  2);

        applyStimulus(1'b0, 1'b1, IN_ZONE, IN_ZONE);
        applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
        checkOutput("play_start_ignored", int'(state), 2);

        applyStimulus(1'b0, 1'b0, IN_ZONE, Y_WRAP);
        checkOutput("ko2_lives2",  int'(lives2),  1);
        checkOutput("ko2_respawn", int'(respawn), 2);
        wait_state(2, 20);

        applyStimulus(1'b0, 1'b0, X_EDGE, Y_WRAP);
        checkOutput("draw_lives1", int'(lives1), 0);
        checkOutput("draw_lives2", int'(lives2), 0);
        checkOutput("draw_winner", int'(winner), 3);
        checkOutput("draw_state",  int'(state),  4);
        applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
        checkOutput("over_pulse_done", int'(respawn), 0);
        checkOutput("over_hold_win",   int'(winner),  3);
        applyStimulus(1'b0, 1'b1, IN_ZONE, IN_ZONE);
        checkOutput("over_to_idle", int'(state),  0);
        checkOutput("idle_winner",  int'(winner), 0);

        // P2 runs out via wrapped y: P1 wins.
        applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
        applyStimulus(1'b0, 1'b1, IN_ZONE, IN_ZONE);
        wait_state(2, 20);
        applyStimulus(1'b0, 1'b0, IN_ZONE, Y_WRAP);
        wait_state(2, 20);
        applyStimulus(1'b0, 1'b0, IN_ZONE, Y_WRAP);
        checkOutput("p1win_lives2",  int'(lives2),  0);
        checkOutput("p1win_respawn", int'(respawn), 2);
        checkOutput("p1win_state",   int'(state),   4);
        checkOutput("p1win_winner",  int'(winner),  1);
        checkOutput("p1win_freeze",  int'(freeze),  1);

        // Reset during respawn aborts the match.
        applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
        applyStimulus(1'b0, 1'b1, IN_ZONE, IN_ZONE);
        applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
        applyStimulus(1'b0, 1'b1, IN_ZONE, IN_ZONE);
        wait_state(2, 20);
        applyStimulus(1'b0, 1'b0, X_EDGE, IN_ZONE);
        checkOutput("pre_abort_state", int'(state), 3);
        applyStimulus(1'b1, 1'b0, IN_ZONE, IN_ZONE);
        checkOutput("abort_state",   int'(state),   0);
        checkOutput("abort_lives1",  int'(lives1),  2);
        checkOutput("abort_respawn", int'(respawn), 0);
        checkOutput("abort_freeze",  int'(freeze),  1);

        // Reset coinciding with a KO in play emits no pulse.
        applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);
        applyStimulus(1'b0, 1'b1, IN_ZONE, IN_ZONE);
        wait_state(2, 20);
        applyStimulus(1'b1, 1'b0, X_EDGE, Y_WRAP);
        checkOutput("ko_reset_respawn", int'(respawn), 0);
        checkOutput("ko_reset_lives2",  int'(lives2),  2);
        applyStimulus(1'b0, 1'b0, IN_ZONE, IN_ZONE);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            st  = ($urandom_range(0, 5) == 0);
            applyStimulus(rst, st, rand_pos(), rand_pos());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
